pq_access_arbiter: RTL and testbench

Shares the P/Q register pair between two requesters, A and B, that drive separate 8-bit words. It performs the following steps:
- arbitrates between the requesters with round-robin priority;
- captures the winner's word and checks its parity;
- writes the 7-bit payload into P or Q, alternating between them;
- completes a four-phase request/acknowledge handshake with the winner.

It is the successor to the single-requester request/confirm controller and sits between the input ports and the P/Q data outputs.

---
 rtl/pq_access_arbiter_pkg.sv | 26 ++
 rtl/pq_access_arbiter_if.sv | 28 ++
 rtl/pq_access_arbiter_register.sv | 22 ++
 rtl/pq_access_arbiter.sv | 107 ++++++++++
 tb/tb_pq_access_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pq_access_arbiter_pkg.sv
// Shared types and helpers for the P/Q access arbiter: state encoding,
// payload width and word parity.
package pq_pkg;

  localparam int DATA_W = 7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_GRANT = S_GRANT,
    ST_CHECK = S_CHECK,
    ST_WRITE = S_WRITE,
    ST_RESP  = S_RESP
  } state_t;

  // 1 means odd parity over the whole word, i.e. a rejected word
  function automatic logic parity(input logic [DATA_W:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pq_access_arbiter_if.sv
// Requester-facing bus of the P/Q access arbiter: two request/data pairs,
// grants, response flags and the shared P/Q register contents.
interface pq_access_arbiter_if;
  import pq_pkg::*;

  logic              reqA;
  logic              reqB;
  logic [DATA_W:0]   dataA;
  logic [DATA_W:0]   dataB;
  logic              grantA;
  logic              grantB;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] dataP;
  logic [DATA_W-1:0] dataQ;
  logic              nextIsQ;

  modport master (
    output reqA, reqB, dataA, dataB,
    input  grantA, grantB, ack, err, dataP, dataQ, nextIsQ
  );

  modport slave (
    input  reqA, reqB, dataA, dataB,
    output grantA, grantB, ack, err, dataP, dataQ, nextIsQ
  );

endinterface

// File: rtl/pq_access_arbiter_register.sv
// Enable register with asynchronous active-low clear, used for P and Q.
module pq_register
  import pq_pkg::*;
#(
  parameter int DATA_W = pq_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// Round-robin arbiter giving requesters A and B four-phase access to the
// alternating P/Q register pair, with parity check on each captured word.
module pq_access_arbiter
  import pq_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  pq_access_arbiter_if.slave   bus
);

  state_t            state;
  logic              last_b;
  logic              next_is_q;
  logic              grant_a;
  logic              grant_b;
  logic              ack_r;
  logic              err_r;
  logic [DATA_W:0]   cap_reg;
  logic              granted_req;
  logic              en_p;
  logic              en_q;
  logic [DATA_W-1:0] data_p;
  logic [DATA_W-1:0] data_q;

  assign granted_req = grant_a ? bus.reqA : bus.reqB;
  assign en_p        = (state == ST_WRITE) && !next_is_q;
  assign en_q        = (state == ST_WRITE) &&  next_is_q;

  // On a tie A wins unless A was the last requester served
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last_b    <= 1'b1;
      next_is_q <= 1'b0;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      cap_reg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.reqA && (!bus.reqB || last_b)) begin
            grant_a <= 1'b1;
            state   <= ST_GRANT;
          end else if (bus.reqB) begin
            grant_b <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cap_reg <= grant_a ? bus.dataA : bus.dataB;
          last_b  <= grant_b;
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (parity(cap_reg)) begin
            err_r <= 1'b1;
            state <= ST_RESP;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          next_is_q <= !next_is_q;
          ack_r     <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (!granted_req) begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pq_register #(.DATA_W(DATA_W)) u_reg_p (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (en_p),
    .d       (cap_reg[DATA_W:1]),
    .q       (data_p)
  );

  pq_register #(.DATA_W(DATA_W)) u_reg_q (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (en_q),
    .d       (cap_reg[DATA_W:1]),
    .q       (data_q)
  );

  assign bus.grantA  = grant_a;
  assign bus.grantB  = grant_b;
  assign bus.ack     = ack_r;
  assign bus.err     = err_r;
  assign bus.dataP   = data_p;
  assign bus.dataQ   = data_q;
  assign bus.nextIsQ = next_is_q;

endmodule

// File: tb/tb_pq_access_arbiter.sv
// Scoreboard bench for pq_access_arbiter: expected responses are queued as
// requests are driven and checked when ack/err rises.
module tb_pq_access_arbiter;

  typedef struct {
    bit         isB;
    bit         ok;
    logic [6:0] p;
    logic [6:0] q;
    bit         nq;
    int         issue;
    int         lat;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc = 0;
  int   checkCount = 0;
  int   errorCount = 0;
  exp_t sb[$];

  logic [6:0] modelP  = '0;
  logic [6:0] modelQ  = '0;
  bit         modelNq = 1'b0;

  bit   respPrev = 1'b0;
  bit   respNow;
  exp_t monEntry;

  pq_access_arbiter_if bus();

  pq_access_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushExpect(input bit isB, input logic [7:0] word, input bit checkLat);
    exp_t e;
    logic [6:0] payload;
    payload = word[7:1];
    e.ok = ((^word) == 1'b0);
    if (e.ok) begin
      if (!modelNq) modelP = payload;
      else          modelQ = payload;
      modelNq = !modelNq;
    end
    e.isB   = isB;
    e.p     = modelP;
    e.q     = modelQ;
    e.nq    = modelNq;
    e.issue = cyc;
    e.lat   = checkLat ? (e.ok ? 4 : 3) : 0;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit isB, input logic [7:0] word, input bit checkLat);
    if (isB) begin
      bus.dataB = word;
      bus.reqB  = 1'b1;
    end else begin
      bus.dataA = word;
      bus.reqA  = 1'b1;
    end
    pushExpect(isB, word, checkLat);
  endtask

  task automatic waitResp(input string tag);
    int n = 0;
    while (!(bus.ack || bus.err) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus.ack || bus.err)) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((bus.grantA || bus.grantB) && n < 20) begin
      tick();
      n++;
    end
    if (bus.grantA || bus.grantB) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic runSingle(input bit isB, input logic [7:0] word);
    applyStimulus(isB, word, 1'b1);
    waitResp("resp_timeout");
    if (isB) bus.reqB = 1'b0;
    else     bus.reqA = 1'b0;
    waitIdle("idle_timeout");
  endtask

  task automatic runTie(input logic [7:0] wordA, input logic [7:0] wordB, input bit firstB);
    bus.dataA = wordA;
    bus.dataB = wordB;
    bus.reqA  = 1'b1;
    bus.reqB  = 1'b1;
    pushExpect(firstB, firstB ? wordB : wordA, 1'b1);
    pushExpect(!firstB, firstB ? wordA : wordB, 1'b0);
    waitResp("tie_first_timeout");
    if (firstB) bus.reqB = 1'b0;
    else        bus.reqA = 1'b0;
    waitIdle("tie_first_idle");
    waitResp("tie_second_timeout");
    bus.reqA = 1'b0;
    bus.reqB = 1'b0;
    waitIdle("tie_second_idle");
  endtask

  // Every rising response is matched against the oldest queued expectation
  always @(posedge clock) begin
    #1;
    respNow = bus.ack || bus.err;
    if (respNow && !respPrev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        monEntry = sb.pop_front();
        checkOutput("resp_grantA", bus.grantA, !monEntry.isB);
        checkOutput("resp_grantB", bus.grantB, monEntry.isB);
        checkOutput("resp_ack", bus.ack, monEntry.ok);
        checkOutput("resp_err", bus.err, !monEntry.ok);
        checkOutput("resp_dataP", bus.dataP, monEntry.p);
        checkOutput("resp_dataQ", bus.dataQ, monEntry.q);
        checkOutput("resp_nextIsQ", bus.nextIsQ, monEntry.nq);
        if (monEntry.lat > 0) checkOutput("resp_latency", cyc - monEntry.issue, monEntry.lat);
      end
    end
    respPrev = respNow;
  end

  initial begin
    bus.reqA  = 1'b0;
    bus.reqB  = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    reset_n   = 1'b0;
    tick();
    tick();
    checkOutput("rst_grantA", bus.grantA, 0);
    checkOutput("rst_grantB", bus.grantB, 0);
    checkOutput("rst_ack", bus.ack, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_dataP", bus.dataP, 0);
    checkOutput("rst_dataQ", bus.dataQ, 0);
    checkOutput("rst_nextIsQ", bus.nextIsQ, 0);
    reset_n = 1'b1;
    tick();

    runSingle(1'b0, 8'hA5);
    checkOutput("a5_dataP", bus.dataP, 7'h52);
    runSingle(1'b0, 8'h0F);
    checkOutput("0f_dataQ", bus.dataQ, 7'h07);
    runSingle(1'b1, 8'h01);
    checkOutput("err_nextIsQ", bus.nextIsQ, 0);

    $display("[TB] tie 1, A expected first");
    runTie(8'h33, 8'h3C, 1'b0);
    runSingle(1'b0, 8'h03);
    $display("[TB] tie 2, B expected first");
    runTie(8'h66, 8'h5A, 1'b1);

    // A holds its request long after ack while B waits
    applyStimulus(1'b0, 8'h99, 1'b1);
    waitResp("hold_resp_timeout");
    applyStimulus(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_ack", bus.ack, 1);
      checkOutput("hold_grantA", bus.grantA, 1);
      checkOutput("hold_grantB", bus.grantB, 0);
    end
    bus.reqA = 1'b0;
    tick();
    checkOutput("hold_idle_grantA", bus.grantA, 0);
    checkOutput("hold_idle_ack", bus.ack, 0);
    tick();
    checkOutput("hold_next_grantB", bus.grantB, 1);
    waitResp("hold_b_timeout");
    bus.reqB = 1'b0;
    waitIdle("hold_b_idle");

    // Reset while the word sits in CHECK
    bus.dataA = 8'h81;
    bus.reqA  = 1'b1;
    tick();
    tick();
    checkOutput("rstmid_pre_grantA", bus.grantA, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_grantA", bus.grantA, 0);
    checkOutput("rstmid_ack", bus.ack, 0);
    checkOutput("rstmid_err", bus.err, 0);
    checkOutput("rstmid_dataP", bus.dataP, 0);
    checkOutput("rstmid_dataQ", bus.dataQ, 0);
    checkOutput("rstmid_nextIsQ", bus.nextIsQ, 0);
    bus.reqA = 1'b0;
    tick();
    reset_n = 1'b1;
    modelP  = '0;
    modelQ  = '0;
    modelNq = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_rst_dataP", bus.dataP, modelP);
    checkOutput("post_rst_dataQ", bus.dataQ, modelQ);
    checkOutput("post_rst_nextIsQ", bus.nextIsQ, modelNq);
    checkOutput("post_rst_ack", bus.ack, 0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
